frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
- Sequences a full-frame Julia render: raster-walks pixel coordinates and hands one (x,y) to a free julia worker per cycle.
- Round-robin fairness across workers.
- Tracks in-flight work and pulses frame_done once every pixel is issued and every worker is idle again.
- Sits between the host start/config logic and the worker array; the memory write path is downstream and unaffected.

Parameters:
NUM_WORKERS, 16, number of worker slots (ports sized by it)
H_RES, 640, pixels per line
V_RES, 480, lines per frame
COORD_W, 10, coordinate width; must hold H_RES-1 and V_RES-1
CNT_W, 19, width of pixel counter; must hold H_RES*V_RES

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  synchronous cancel; highest priority after rst
worker_ready  in  NUM_WORKERS  per-worker level, 1 = idle and able to accept a pixel
worker_start  out  NUM_WORKERS  one-hot (or zero) single-cycle dispatch pulse
x_flat  out  NUM_WORKERS*COORD_W  per-worker held x; slice i = bits [i*COORD_W +: COORD_W]
y_flat  out  NUM_WORKERS*COORD_W  per-worker held y, same packing
busy  out  1  high in any state other than IDLE
frame_done  out  1  single-cycle pulse at frame completion
pixels_issued  out  CNT_W  pixels dispatched in the current or last frame

Behaviour:
- Reset (async, rst=1): state=IDLE, worker_start=0, x_flat=0, y_flat=0, busy=0, frame_done=0, pixels_issued=0, cur_x=cur_y=0, rr_ptr=0, pend=0.
- States:
  - IDLE: start=1 -> DISPATCH, clears pixels_issued, cur_x=cur_y=0.
  - DISPATCH: issue pixels. After issuing (H_RES-1,V_RES-1), go to DRAIN.
  - DRAIN: wait until pend==0 and worker_ready all ones -> DONE.
  - DONE: frame_done=1 for exactly this one cycle -> IDLE.
- Eligibility: worker i is eligible iff worker_ready[i]=1 and pend[i]=0.
  - pend[i] is set on the cycle worker_start[i] is driven.
  - pend[i] is cleared on the first cycle worker_ready[i] is sampled 0.
  - This prevents re-dispatch before the worker has dropped ready. Workers must drop ready within 2 cycles of start.
- Arbitration: each DISPATCH cycle, select the first eligible index at or after rr_ptr, scanning upward and wrapping modulo NUM_WORKERS.
  - On grant g: rr_ptr <= (g+1) mod NUM_WORKERS.
  - If no worker is eligible, no grant, and rr_ptr holds.
- Dispatch is registered. worker_start[g]=1 the cycle after selection; slice g of x_flat/y_flat is loaded with cur_x/cur_y the same edge and held until that worker's next dispatch.
- At most one pixel is dispatched per cycle, so peak throughput is 1 pixel/clk.
- Raster: per grant, cur_x+1. When cur_x==H_RES-1, cur_x wraps to 0 and cur_y+1. The grant of (H_RES-1,V_RES-1) is the last; no wrap occurs past the frame.
- pixels_issued increments by 1 per grant and saturates at H_RES*V_RES.
- start is ignored outside IDLE, including in DONE.
- abort=1 in any state:
  - Next state IDLE, pend=0, worker_start=0, no frame_done pulse.
  - pixels_issued and x_flat/y_flat hold.
  - In-flight workers finish unsupervised.
- Simultaneous abort and start in IDLE: abort wins and the state stays IDLE.
- rst asserted mid-frame: immediate return to the reset values above, regardless of clock.
- worker_ready toggling on a worker with pend=0 and no dispatch has no effect.

Test Plan:
- Reset, then start with H_RES=4, V_RES=2, NUM_WORKERS=4, and all workers acking by dropping ready 1 cycle after start and rising 3 cycles later -> 8 grants, coordinates (0,0)..(3,1) in raster order, pixels_issued=8, one frame_done pulse, busy falls the cycle after.
- Only workers 1 and 3 ready, rr_ptr=0 -> grants go 1, 3, 1, 3 and never to 0 or 2; each slice holds its coordinate between grants.
- Worker 2 holds ready high for 2 cycles after start -> no second worker_start[2] until ready is seen low and then high again.
- Last pixel dispatched while worker 5 is still busy -> DRAIN holds and frame_done stays 0 until worker_ready[5] rises, then pulses once.
- abort asserted in DISPATCH after 37 grants -> IDLE next cycle, pixels_issued=37, no frame_done; a fresh start restarts at (0,0) with pixels_issued cleared.
- rst pulsed asynchronously mid-DISPATCH (between clock edges) -> all outputs return to reset values before the next clk edge; start pulsed while busy has no effect on the coordinate sequence.

Source files
------------

// File: rtl/frame_scheduler.sv
// Raster-order pixel dispatcher for a pool of Julia workers: round-robin grant
// among ready, non-pending workers, then a drain phase and a one-cycle frame_done.
module frame_scheduler #(
   parameter int NUM_WORKERS = 16,
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int COORD_W     = 10,
   parameter int CNT_W       = 19
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           abort,
   input  logic [NUM_WORKERS-1:0]         worker_ready,
   output logic [NUM_WORKERS-1:0]         worker_start,
   output logic [NUM_WORKERS*COORD_W-1:0] x_flat,
   output logic [NUM_WORKERS*COORD_W-1:0] y_flat,
   output logic                           busy,
   output logic                           frame_done,
   output logic [CNT_W-1:0]               pixels_issued
);

   localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_RES - 1);
   localparam logic [CNT_W-1:0]   PIX_TOTAL = CNT_W'(H_RES * V_RES);
   localparam logic [PTR_W:0]     NW_EXT    = (PTR_W+1)'(NUM_WORKERS);
   localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_WORKERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [COORD_W-1:0]     cur_x_q, cur_x_d;
   logic [COORD_W-1:0]     cur_y_q, cur_y_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_WORKERS-1:0] pend_q, pend_d;
   logic [NUM_WORKERS-1:0] start_q, start_d;
   logic [CNT_W-1:0]       issued_q, issued_d;

   logic [NUM_WORKERS-1:0] eligible;
   logic [PTR_W-1:0]       scan_idx [NUM_WORKERS];
   logic                   grant_vld;
   logic [PTR_W-1:0]       grant_idx;
   logic                   last_pixel;

   assign eligible   = worker_ready & ~pend_q;
   assign last_pixel = (cur_x_q == X_LAST) && (cur_y_q == Y_LAST);

   // scan_idx[k] is the k-th candidate in round-robin order starting at rr_ptr
   generate
      for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_scan
         logic [PTR_W:0] sum;
         assign sum          = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
         assign scan_idx[gi] = (sum >= NW_EXT) ? PTR_W'(sum - NW_EXT) : PTR_W'(sum);
      end
   endgenerate

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_WORKERS; k++) begin
         if (!grant_vld && eligible[scan_idx[k]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[k];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      rr_ptr_d = rr_ptr_q;
      issued_d = issued_q;
      start_d  = '0;
      // A pending slot is released as soon as its worker is seen busy
      pend_d   = pend_q & worker_ready;
      if (abort) begin
         state_d = S_IDLE;
         pend_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d  = S_DISPATCH;
                  cur_x_d  = '0;
                  cur_y_d  = '0;
                  issued_d = '0;
               end
            end
            S_DISPATCH: begin
               if (grant_vld) begin
                  start_d[grant_idx] = 1'b1;
                  pend_d[grant_idx]  = 1'b1;
                  rr_ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
                  if (issued_q != PIX_TOTAL) begin
                     issued_d = issued_q + 1'b1;
                  end
                  if (last_pixel) begin
                     state_d = S_DRAIN;
                  end else if (cur_x_q == X_LAST) begin
                     cur_x_d = '0;
                     cur_y_d = cur_y_q + 1'b1;
                  end else begin
                     cur_x_d = cur_x_q + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if ((pend_q == '0) && (&worker_ready)) begin
                  state_d = S_DONE;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         rr_ptr_q <= '0;
         pend_q   <= '0;
         start_q  <= '0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         rr_ptr_q <= rr_ptr_d;
         pend_q   <= pend_d;
         start_q  <= start_d;
         issued_q <= issued_d;
      end
   end

   // Each worker's coordinate slice is captured with its grant and held until the next one
   generate
      for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_slice
         logic [COORD_W-1:0] x_q;
         logic [COORD_W-1:0] y_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               x_q <= '0;
               y_q <= '0;
            end else if (start_d[gi]) begin
               x_q <= cur_x_q;
               y_q <= cur_y_q;
            end
         end
         assign x_flat[gi*COORD_W +: COORD_W] = x_q;
         assign y_flat[gi*COORD_W +: COORD_W] = y_q;
      end
   endgenerate

   assign worker_start  = start_q;
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = (state_q == S_DONE);
   assign pixels_issued = issued_q;

endmodule
